mult8_shift_add: RTL and testbench
==================================

Name: mult8_shift_add

Overview:
Sequential unsigned 8x8 -> 16-bit multiplier. It sits directly downstream of the 8-bit ripple adder (FullAdder8bit) and consumes its Sum/Cout as the partial-product adder, one add-and-shift step per clock. Operands arrive over a valid/ready handshake and the product leaves over another valid/ready handshake. It is the first sequential arithmetic unit built on the adder chain.

Parameters:
WIDTH, 8, operand width; fixed at 8 to match the adder; any other value is an elaboration error.

Ports:
clk  input  1  single clock, all state updates on rising edge
rst_n  input  1  synchronous, active-low reset
in_valid  input  1  operand pair A/B is valid
in_ready  output  1  block can accept operands (high only in IDLE)
A  input  8  multiplicand (unsigned)
B  input  8  multiplier (unsigned)
out_valid  output  1  P holds a completed product
out_ready  input  1  consumer accepts P
P  output  16  product A*B
busy  output  1  high in RUN or DONE

Behaviour:
- Reset: one clock, synchronous, active-low. Sampled rst_n=0 -> state=IDLE, acc_hi=0, q=0, m=0, cnt=0. Outputs after reset: in_ready=1, out_valid=0, P=0, busy=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: m<=A, q<=B, acc_hi<=0, cnt<=0, go to RUN.
- RUN (exactly 8 cycles, cnt 0..7):
  - Adder inputs: A=acc_hi, B=(q[0] ? m : 8'h00), Cin=0.
  - Shift step: {acc_hi,q} <= {Cout,Sum,q[7:1]}, so the 17-bit concatenation is shifted right by 1.
  - cnt<=cnt+1.
  - When cnt==7, go to DONE after this step.
  - in_valid is ignored and in_ready=0.
- DONE:
  - out_valid=1, P={acc_hi,q}.
  - P and out_valid stay stable until out_valid&&out_ready. On that handshake, go to IDLE.
  - in_ready rises the following cycle; there is no same-cycle accept of new operands.
- Latency: accept in cycle T, out_valid=1 in cycle T+9. Best-case throughput is one product per 10 cycles.
- Width rule: adder Cout is never dropped; it becomes bit 7 of the next acc_hi. The result is exact for 0xFF*0xFF=0xFE01.
- P in IDLE/RUN: holds its last completed value (0 after reset). It is only meaningful while out_valid=1.
- Operand changes on A/B after acceptance have no effect.
- Reset mid-RUN or mid-DONE: abort immediately. The product is discarded, out_valid=0 the next cycle, and all registers are cleared.
- Simultaneous in_valid and out_ready in DONE: only the output handshake completes; the operand is not accepted.
- cnt is 3 bits and wraps to 0 on leaving RUN. It is not used outside RUN.

Decomposition:
- Package mult8_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t
  - localparam WIDTH=8
  - localparam STEPS=8
- Sub-module: one instance of the existing FullAdder8bit for the partial-sum add. No other sub-modules; the FSM and datapath registers live in mult8_shift_add.

Test Plan:
1. Reset, then A=8'd13, B=8'd11, in_valid=1 for 1 cycle, out_ready=1 -> in_ready=0 next cycle; out_valid=1 exactly 9 cycles after accept; P=16'h008F; in_ready=1 the cycle after the output handshake.
2. A=8'hFF, B=8'hFF -> P=16'hFE01 (checks Cout retention every step). Then A=8'h00, B=8'hFF -> P=16'h0000. Then A=8'h80, B=8'h02 -> P=16'h0100.
3. Backpressure: A=8'h0F, B=8'h10, out_ready=0 for 5 cycles after out_valid rises -> P=16'h00F0 and out_valid held stable for all 5 cycles; in_ready=0 throughout; completes when out_ready=1.
4. Busy rejection: while in RUN, drive in_valid=1 with A=8'h55, B=8'h55 -> ignored; the original product is unaffected; no extra out_valid pulse.
5. Reset mid-operation: accept A=8'hAA, B=8'h03, assert rst_n=0 for 1 cycle at RUN cnt=4 -> next cycle state IDLE, out_valid=0, P=0, in_ready=1; a new A=8'h02, B=8'h03 then yields P=16'h0006.
6. Random: 1000 random A/B pairs with random out_ready stalls -> every P equals A*B, and exactly one out_valid handshake per accepted input.

Source files
------------

// File: rtl/mult8_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
package mult8_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t;

  localparam int WIDTH = 8;
  localparam int STEPS = 8;

endpackage

// File: rtl/FullAdder8bit.sv
// 8-bit adder with carry in/out used as the partial-product adder.
module FullAdder8bit (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [7:0] Sum,
  output logic       Cout
);

  assign {Cout, Sum} = {1'b0, A} + {1'b0, B} + {8'b0, Cin};

endmodule

// File: rtl/mult8_shift_add.sv
// Sequential unsigned 8x8 multiplier: one add-and-shift step per clock.
// Handshakes: a transfer happens on a rising edge where valid && ready;
// valid, once high, holds its payload stable until that edge.
module mult8_shift_add
  import mult8_pkg::*;
#(
  parameter int WIDTH = mult8_pkg::WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   P,
  output logic                 busy
);

  if (WIDTH != 8) begin : g_width_check
    $error("mult8_shift_add: WIDTH must be 8 to match FullAdder8bit");
  end

  mult_state_t          state;
  logic [WIDTH-1:0]     acc_hi;
  logic [WIDTH-1:0]     q;
  logic [WIDTH-1:0]     m;
  logic [2:0]           cnt;
  logic [2*WIDTH-1:0]   p_reg;

  logic [WIDTH-1:0]     add_b;
  logic [WIDTH-1:0]     sum;
  logic                 cout;
  logic [2*WIDTH-1:0]   shifted;

  assign add_b = q[0] ? m : '0;

  FullAdder8bit u_adder (
    .A    (acc_hi),
    .B    (add_b),
    .Cin  (1'b0),
    .Sum  (sum),
    .Cout (cout)
  );

  // Carry-out becomes the new top bit so the 17-bit {cout,sum,q} never loses it.
  assign shifted = {cout, sum, q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc_hi <= '0;
      q      <= '0;
      m      <= '0;
      cnt    <= '0;
      p_reg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            m      <= A;
            q      <= B;
            acc_hi <= '0;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          {acc_hi, q} <= shifted;
          cnt         <= cnt + 3'd1;
          if (cnt == 3'(STEPS - 1)) begin
            p_reg <= shifted;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign P         = p_reg;

endmodule

// File: tb/tb_mult8_shift_add.sv
// Self-checking bench for mult8_shift_add with a product scoreboard.
module tb_mult8_shift_add;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] P;
  logic        busy;

  logic [15:0] exp_q[$];
  int n_checks;
  int n_fails;
  int n_accepts;
  int n_handshakes;

  mult8_shift_add dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .P         (P),
    .busy      (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) step();
    rst_n = 1'b1;
  endtask

  // scoreboard: compare every output handshake against the expected queue
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      logic [15:0] e;
      n_handshakes++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fails++;
        $display("FAIL unexpected_output: P=%h with empty expected queue", P);
      end else begin
        e = exp_q.pop_front();
        if (P !== e) begin
          n_fails++;
          $display("FAIL product: P=%h expected %h", P, e);
        end
      end
    end
  end

  // driver: present one operand pair while idle, scoreboard gets A*B
  task automatic drive_accept(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    A = a;
    B = b;
    in_valid = 1'b1;
    prod = 16'(a) * 16'(b);
    exp_q.push_back(prod);
    n_accepts++;
    step();
    in_valid = 1'b0;
    A = $urandom_range(0, 255);
    B = $urandom_range(0, 255);
  endtask

  // waits for out_valid; returns edges elapsed since the accept edge, or -1
  task automatic wait_out(output int lat);
    lat = -1;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) begin
        lat = i;
        break;
      end
      step();
    end
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int stall);
    int lat;
    logic [15:0] held;
    out_ready = (stall == 0);
    drive_accept(a, b);
    wait_out(lat);
    n_checks++;
    if (lat != 8) begin
      n_fails++;
      $display("FAIL latency: got %0d edges after accept, expected 8 (a=%h b=%h)", lat, a, b);
      if (lat < 0) begin
        apply_reset(1);
        exp_q.delete();
        return;
      end
    end
    held = P;
    for (int i = 0; i < stall; i++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b1 || P !== held || in_ready !== 1'b0) begin
        n_fails++;
        $display("FAIL stall_hold: out_valid=%b P=%h in_ready=%b expected 1/%h/0", out_valid, P, in_ready, held);
      end
    end
    out_ready = 1'b1;
    step();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL release: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    apply_reset(2);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || P !== 16'h0000 || busy !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b P=%h busy=%b expected 1/0/0000/0", in_ready, out_valid, P, busy);
    end
  endtask

  task automatic test_basic();
    int lat;
    out_ready = 1'b1;
    drive_accept(8'd13, 8'd11);
    n_checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      n_fails++;
      $display("FAIL after_accept: in_ready=%b busy=%b expected 0/1", in_ready, busy);
    end
    wait_out(lat);
    n_checks++;
    if (lat != 8) begin
      n_fails++;
      $display("FAIL basic_latency: got %0d expected 8", lat);
    end
    n_checks++;
    if (P !== 16'h008F) begin
      n_fails++;
      $display("FAIL basic_product: P=%h expected 008f", P);
    end
    step();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fails++;
      $display("FAIL basic_return: in_ready=%b out_valid=%b busy=%b expected 1/0/0", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_corners();
    do_op(8'hFF, 8'hFF, 0);
    n_checks++;
    if (P !== 16'hFE01) begin
      n_fails++;
      $display("FAIL max_product: P=%h expected fe01", P);
    end
    do_op(8'h00, 8'hFF, 0);
    n_checks++;
    if (P !== 16'h0000) begin
      n_fails++;
      $display("FAIL zero_product: P=%h expected 0000", P);
    end
    do_op(8'h80, 8'h02, 0);
    n_checks++;
    if (P !== 16'h0100) begin
      n_fails++;
      $display("FAIL shift_product: P=%h expected 0100", P);
    end
  endtask

  task automatic test_backpressure();
    do_op(8'h0F, 8'h10, 5);
    n_checks++;
    if (P !== 16'h00F0) begin
      n_fails++;
      $display("FAIL backpressure_product: P=%h expected 00f0", P);
    end
  endtask

  task automatic test_busy_reject();
    int lat;
    int hs_before;
    out_ready = 1'b1;
    drive_accept(8'h21, 8'h07);
    step();
    step();
    A = 8'h55;
    B = 8'h55;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fails++;
        $display("FAIL busy_in_ready: in_ready=%b expected 0", in_ready);
      end
      step();
    end
    in_valid = 1'b0;
    wait_out(lat);
    n_checks++;
    if (P !== 16'h00E7) begin
      n_fails++;
      $display("FAIL busy_product: P=%h expected 00e7", P);
    end
    hs_before = n_handshakes;
    repeat (15) step();
    n_checks++;
    if (n_handshakes != hs_before + 1 || out_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL busy_extra_pulse: handshakes=%0d expected %0d, out_valid=%b", n_handshakes - hs_before, 1, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    drive_accept(8'hAA, 8'h03);
    repeat (4) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    void'(exp_q.pop_back());
    n_accepts--;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || P !== 16'h0000 || busy !== 1'b0) begin
      n_fails++;
      $display("FAIL mid_reset: in_ready=%b out_valid=%b P=%h busy=%b expected 1/0/0000/0", in_ready, out_valid, P, busy);
    end
    do_op(8'h02, 8'h03, 0);
    n_checks++;
    if (P !== 16'h0006) begin
      n_fails++;
      $display("FAIL post_reset_product: P=%h expected 0006", P);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      do_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), $urandom_range(0, 3));
    end
    step();
    n_checks++;
    if (n_handshakes != n_accepts || exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL handshake_count: outputs=%0d accepts=%0d pending=%0d", n_handshakes, n_accepts, exp_q.size());
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails = 0;
    n_accepts = 0;
    n_handshakes = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    A = 8'h00;
    B = 8'h00;
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_busy_reject();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
